debounce_bank: RTL
==================

Name: debounce_bank

Overview:
- Parametrised multi-channel debouncer; next generation of the single-channel keypad debouncer.
- Each channel synchronises a raw asynchronous input and qualifies it over STABLE_CYCLES enabled ticks.
- Each channel produces a clean level plus one-cycle press and release pulses.
- Sits between the keypad row/column pins and the keypad scanner FSM.
- Replaces the debouncer_counter_en/debounce_done handshake with per-channel events.

Parameters:
- N_CH, 4, number of independent input channels.
- STABLE_CYCLES, 4, number of consecutive enabled ticks the synced input must hold before a change is accepted; must be >= 1.
- CNT_W, $clog2(STABLE_CYCLES+1), width of each per-channel stability counter.
- ACTIVE_LOW_IN, 1, when 1 raw inputs are inverted after synchronisation (pulled-up keypad lines).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset; state clears on the rising clk edge while reset=0.
- tick_en  input  1  sample strobe; counters advance only on cycles with tick_en=1.
- raw_in  input  N_CH  asynchronous raw inputs.
- level_out  output  N_CH  debounced level per channel, active-high.
- press_pulse  output  N_CH  one-cycle pulse when a channel is accepted as pressed.
- release_pulse  output  N_CH  one-cycle pulse when a channel is accepted as released.
- any_held  output  1  OR of level_out.

Behaviour:
- Reset (reset=0 at a clk edge):
  - Sync flops are set to the inactive value; inactive value is 1 if ACTIVE_LOW_IN, else 0.
  - All channel FSMs go to IDLE and counters go to 0.
  - level_out, press_pulse, release_pulse and any_held are all 0.
  - Reset overrides all other inputs, including mid-count.
- Synchroniser: 2 flops per channel on raw_in. Optional inversion per ACTIVE_LOW_IN gives s[i].
- Per-channel FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: s=1 -> PRESS_WAIT, cnt=0. tick_en is not required for this transition.
  - PRESS_WAIT:
    - s=0 -> IDLE, cnt=0; a glitch is rejected and no pulse is issued.
    - tick_en=1 and s=1 and cnt==STABLE_CYCLES-1 -> HELD, cnt=0.
    - tick_en=1 and s=1 otherwise -> cnt+1.
    - tick_en=0 and s=1 -> hold.
  - HELD: s=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: symmetric to PRESS_WAIT with s inverted.
    - s=1 -> HELD.
    - Qualified -> IDLE.
- Outputs are registered:
  - level_out[i]=1 in HELD or RELEASE_WAIT.
  - press_pulse[i]=1 for exactly the one cycle after the PRESS_WAIT->HELD transition.
  - release_pulse[i]=1 for exactly the one cycle after the RELEASE_WAIT->IDLE transition.
- Latency with tick_en tied to 1: press_pulse and the level_out rise are visible after edge STABLE_CYCLES+3 following the edge at which raw_in is first sampled active.
  - Breakdown: 2 sync edges, 1 IDLE->PRESS_WAIT edge, STABLE_CYCLES count/qualify edges.
  - For STABLE_CYCLES=4 this is after the 7th edge.
- Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- The counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- STABLE_CYCLES=1: a single enabled tick qualifies the change.

Decomposition:
- Package debounce_pkg holds:
  - enum state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - default constants DEF_STABLE_CYCLES=4 and DEF_N_CH=4.
- Sub-module debounce_channel holds one synchroniser, one FSM and one counter with scalar ports.
- debounce_bank instantiates N_CH copies in a generate loop and ORs level_out into any_held.

Test Plan:
- Reset: hold reset=0 for 2 cycles with raw_in toggling -> all outputs 0; after release with raw inactive, outputs stay 0 for 20 cycles.
- Clean press, then release, on channel 0:
  - Setup: ACTIVE_LOW_IN=0, tick_en=1, raw_in[0] 0->1.
  - Press: press_pulse[0]=1 for exactly one cycle after the 7th edge; level_out[0]=1 and any_held=1 from then on.
  - Release: raw_in[0] 1->0 -> release_pulse[0] one cycle after 7 edges; level_out[0]=0.
- Glitch rejection: raw_in[1] high for 3 cycles, then low -> no press_pulse and level_out[1] stays 0; a 2-cycle low glitch while HELD -> no release_pulse.
- tick_en gating: tick_en asserted every 4th cycle, raw_in[2] held high -> press_pulse[2] only after 4 enabled ticks (cycles 3+~16); no advance on idle cycles.
- Simultaneous channels plus inversion:
  - Setup: ACTIVE_LOW_IN=1, raw_in 4'b1111 -> 4'b0101.
  - Response: press_pulse=4'b1010 in a single cycle; level_out=4'b1010.
- Mid-operation reset: reset=0 while channel 3 is in PRESS_WAIT with cnt=2 -> next cycle level_out=0 and no pulse; after reset the full qualification restarts from cnt=0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the keypad debouncer bank.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_N_CH          = 4;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, qualify FSM and stability counter.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter bit ACTIVE_LOW_IN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_en,
    input  logic raw_in,
    output logic level_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic             INACTIVE = ACTIVE_LOW_IN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_reg, sync2_reg;
    logic             s;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, press_reg, release_reg;
    logic             press_next, release_next;

    // Sync flops reset to the idle line level so reset release never looks like a press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= INACTIVE;
            sync2_reg <= INACTIVE;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = ACTIVE_LOW_IN ? ~sync2_reg : sync2_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (tick_en) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next = HELD;
                        cnt_next   = '0;
                        press_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (!s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (tick_en) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next   = IDLE;
                        cnt_next     = '0;
                        release_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Level is registered from the next state so it rises on the same edge as the press pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_reg   <= (state_next == HELD) || (state_next == RELEASE_WAIT);
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    assign level_out     = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels with a combined "any key held" flag.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter bit ACTIVE_LOW_IN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick_en,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            any_held
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_channel #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .CNT_W         (CNT_W),
                .ACTIVE_LOW_IN (ACTIVE_LOW_IN)
            ) u_ch (
                .clk           (clk),
                .reset         (reset),
                .tick_en       (tick_en),
                .raw_in        (raw_in[gi]),
                .level_out     (level_out[gi]),
                .press_pulse   (press_pulse[gi]),
                .release_pulse (release_pulse[gi])
            );
        end
    endgenerate

    assign any_held = |level_out;

endmodule
